// File: rtl/melody_sequencer.sv
// Self-timed melody player: fetches {duration, ticks} entries from a song ROM,
// times each note internally and drives a square-wave tone directly.
// Ports:
//   clk, clr_n (async active-low reset)
//   start, stop, song_sel, loop_en, tempo_scale : control
//   rom_en, rom_addr -> ROM read request; rom_data <- entry, one cycle later
//   tone, busy, note_strobe, cur_ticks, done : status and audio outputs
module melody_sequencer #(
  parameter int TICKBITS    = 18,
  parameter int DURBITS     = 3,
  parameter int NUM_SONGS   = 4,
  parameter int SONG_DEPTH  = 64,
  parameter int UNIT_CYCLES = 2083333,
  parameter int GAP_CYCLES  = 1000000
) (
  input  logic                                  clk,
  input  logic                                  clr_n,
  input  logic                                  start,
  input  logic                                  stop,
  input  logic [$clog2(NUM_SONGS)-1:0]          song_sel,
  input  logic                                  loop_en,
  input  logic [1:0]                            tempo_scale,
  output logic                                  rom_en,
  output logic [$clog2(NUM_SONGS*SONG_DEPTH)-1:0] rom_addr,
  input  logic [DURBITS+TICKBITS-1:0]           rom_data,
  output logic                                  tone,
  output logic                                  busy,
  output logic                                  note_strobe,
  output logic [TICKBITS-1:0]                   cur_ticks,
  output logic                                  done
);

  localparam int SW = $clog2(NUM_SONGS);
  localparam int IW = $clog2(SONG_DEPTH);
  localparam int EW = DURBITS + TICKBITS;
  // Longest note: 24 units at half tempo.
  localparam int DW = $clog2(48 * UNIT_CYCLES + 1);
  localparam logic [DW-1:0] GAP  = DW'(GAP_CYCLES);
  localparam logic [IW-1:0] LAST = IW'(SONG_DEPTH - 1);

  if (UNIT_CYCLES > 32'h7fff_ffff / 48) begin : g_bad_unit
    $error("UNIT_CYCLES too large for the duration counter");
  end
  if (GAP_CYCLES >= 6 * (UNIT_CYCLES / 2)) begin : g_bad_gap
    $error("GAP_CYCLES must be shorter than the shortest note");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_LOAD, S_PLAY, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     song_q, song_d;
  logic              loop_q, loop_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [EW-1:0]     data_q, data_d;
  logic [DW-1:0]     dur_q, dur_d;
  logic [TICKBITS-1:0] hp_q, hp_d;
  logic [TICKBITS-1:0] ticks_q, ticks_d;
  logic              tone_q, tone_d;
  logic              stb_q, stb_d;

  logic [DURBITS-1:0]  code;
  logic [TICKBITS-1:0] ent_ticks;
  logic [4:0]          units;
  logic [DW-1:0]       ulen;
  logic [DW-1:0]       note_len;
  logic                is_end;
  logic                active;

  assign code      = data_q[TICKBITS +: DURBITS];
  assign ent_ticks = data_q[TICKBITS-1:0];

  always_comb begin
    units = 5'd0;
    case (code)
      DURBITS'(1): units = 5'd24;
      DURBITS'(2): units = 5'd12;
      DURBITS'(3): units = 5'd16;
      DURBITS'(4): units = 5'd6;
      DURBITS'(5): units = 5'd8;
      default:     units = 5'd0;
    endcase
  end

  always_comb begin
    ulen = DW'(UNIT_CYCLES);
    case (tempo_scale)
      2'd1:    ulen = DW'(UNIT_CYCLES / 2);
      2'd2:    ulen = DW'(2 * UNIT_CYCLES);
      default: ulen = DW'(UNIT_CYCLES);
    endcase
  end

  assign is_end   = (units == 5'd0);
  assign note_len = DW'(units) * ulen;

  // Tone runs only while the note has more than GAP cycles left.
  assign active = (state_q == S_PLAY) && (ticks_q != '0) && (dur_q >= GAP);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_FETCH;
        S_FETCH: state_d = S_WAIT;
        S_WAIT:  state_d = S_LOAD;
        S_LOAD: begin
          if (!is_end)                  state_d = S_PLAY;
          else if (loop_q && idx_q != '0) state_d = S_FETCH;
          else                          state_d = S_DONE;
        end
        S_PLAY: begin
          if (dur_q == '0)
            state_d = (idx_q == LAST && !loop_q) ? S_DONE : S_FETCH;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    rom_en      = (state_q == S_FETCH);
    rom_addr    = {song_q, idx_q};
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    tone        = tone_q & active;
    note_strobe = stb_q;
    cur_ticks   = ticks_q;
  end

  always_comb begin
    song_d  = song_q;
    loop_d  = loop_q;
    idx_d   = idx_q;
    data_d  = data_q;
    dur_d   = dur_q;
    hp_d    = hp_q;
    ticks_d = ticks_q;
    tone_d  = tone_q;
    stb_d   = 1'b0;
    if (stop) begin
      dur_d   = '0;
      hp_d    = '0;
      ticks_d = '0;
      tone_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            song_d = song_sel;
            loop_d = loop_en;
            idx_d  = '0;
          end
        end
        S_WAIT: data_d = rom_data;
        S_LOAD: begin
          if (is_end) begin
            if (loop_q && idx_q != '0) idx_d = '0;
            else                       ticks_d = '0;
          end else begin
            dur_d   = note_len - DW'(1);
            ticks_d = ent_ticks;
            stb_d   = 1'b1;
            tone_d  = 1'b0;
            hp_d    = '0;
          end
        end
        S_PLAY: begin
          if (active) begin
            if (hp_q == ticks_q - TICKBITS'(1)) begin
              hp_d   = '0;
              tone_d = ~tone_q;
            end else begin
              hp_d = hp_q + TICKBITS'(1);
            end
          end else begin
            hp_d   = '0;
            tone_d = 1'b0;
          end
          if (dur_q == '0) begin
            if (idx_q == LAST) begin
              idx_d = '0;
              if (!loop_q) ticks_d = '0;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            dur_d = dur_q - DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      song_q  <= '0;
      loop_q  <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
      dur_q   <= '0;
      hp_q    <= '0;
      ticks_q <= '0;
      tone_q  <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      song_q  <= song_d;
      loop_q  <= loop_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      dur_q   <= dur_d;
      hp_q    <= hp_d;
      ticks_q <= ticks_d;
      tone_q  <= tone_d;
      stb_q   <= stb_d;
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer: a per-cycle song model predicts
// ROM reads, note starts, done pulses and tone/busy edges.
`timescale 1ns/1ps
module tb_melody_sequencer;

  localparam int TB = 18;
  localparam int DB = 3;
  localparam int NS = 4;
  localparam int SD = 16;
  localparam int UC = 10;
  localparam int GC = 5;
  localparam int RW = DB + TB;
  localparam int AW = $clog2(NS*SD);
  localparam int SW = $clog2(NS);
  localparam int MAXC = 16384;
  localparam int NOSTOP = 1 << 30;

  logic clk = 0;
  logic clr_n = 0;
  logic start = 0;
  logic stop = 0;
  logic loop_en = 0;
  logic [SW-1:0] song_sel = '0;
  logic [1:0] tempo_scale = '0;
  logic rom_en;
  logic [AW-1:0] rom_addr;
  logic [RW-1:0] rom_data;
  logic tone, busy, note_strobe, done;
  logic [TB-1:0] cur_ticks;

  logic [RW-1:0] rom [NS*SD];

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;
  ev_t expq[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_en = 0;
  logic p_tone = 0;
  logic p_busy = 0;
  string kn [5] = '{"rom_addr", "note_ticks", "done", "tone", "busy"};

  bit a_rom [MAXC];
  int a_addr [MAXC];
  bit a_stb [MAXC];
  int a_tk [MAXC];
  bit a_done [MAXC];
  bit a_tone [MAXC];
  bit a_busy [MAXC];

  melody_sequencer #(
    .TICKBITS(TB), .DURBITS(DB), .NUM_SONGS(NS),
    .SONG_DEPTH(SD), .UNIT_CYCLES(UC), .GAP_CYCLES(GC)
  ) dut (
    .clk(clk), .clr_n(clr_n), .start(start), .stop(stop),
    .song_sel(song_sel), .loop_en(loop_en),
    .tempo_scale(tempo_scale), .rom_en(rom_en),
    .rom_addr(rom_addr), .rom_data(rom_data), .tone(tone),
    .busy(busy), .note_strobe(note_strobe),
    .cur_ticks(cur_ticks), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Synchronous ROM; junk on the bus when not reading.
  always @(posedge clk) begin
    if (rom_en) rom_data <= rom[rom_addr];
    else        rom_data <= RW'($urandom);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic see(int kind, int val);
    ev_t e;
    checks++;
    if (expq.size() == 0) begin
      failures++;
      $display("FAIL unexpected %s: got %0d at cycle %0d, expected nothing",
               kn[kind], val, cyc);
    end else begin
      e = expq.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        failures++;
        $display("FAIL event: got %s=%0d at cycle %0d, expected %s=%0d at cycle %0d",
                 kn[kind], val, cyc, kn[e.kind], e.val, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (rom_en === 1'b1)      see(0, int'(rom_addr));
      if (note_strobe === 1'b1) see(1, int'(cur_ticks));
      if (done === 1'b1)        see(2, 0);
      if (tone !== p_tone)      see(3, int'(tone));
      if (busy !== p_busy)      see(4, int'(busy));
    end
    p_tone = tone;
    p_busy = busy;
  end

  function automatic int units_of(int code);
    case (code)
      1: return 24;
      2: return 12;
      3: return 16;
      4: return 6;
      5: return 8;
      default: return 0;
    endcase
  endfunction

  function automatic int ulen_of(int s);
    case (s)
      1: return UC / 2;
      2: return UC * 2;
      default: return UC;
    endcase
  endfunction

  function automatic void push_ev(int k, int v, int c);
    ev_t e;
    e.kind = k;
    e.val = v;
    e.cyc = c;
    expq.push_back(e);
  endfunction

  // Cycle 0 is the cycle where start is high; stop_at is the cycle where
  // stop is high. Returns the last busy cycle.
  function automatic int run_model(int song, bit lp, int scale,
                                   int stop_at, int base);
    int c = 1;
    int idx = 0;
    int last = 0;
    int endc;
    bit fin = 0;
    bit pt = 0;
    bit pb = 0;
    for (int i = 0; i < MAXC; i++) begin
      a_rom[i] = 0; a_addr[i] = 0; a_stb[i] = 0; a_tk[i] = 0;
      a_done[i] = 0; a_tone[i] = 0; a_busy[i] = 0;
    end
    while (!fin && c <= stop_at && c < MAXC - 600) begin
      int e;
      int code;
      int tk;
      int u;
      e = int'(rom[song*SD + idx]);
      code = e >> TB;
      tk = e & ((1 << TB) - 1);
      u = units_of(code);
      a_rom[c] = 1;
      a_addr[c] = song*SD + idx;
      if (u == 0) begin
        if (lp && idx != 0) begin
          idx = 0;
          c += 3;
        end else begin
          a_done[c+3] = 1;
          last = c + 3;
          fin = 1;
        end
      end else begin
        int n;
        int p;
        n = u * ulen_of(scale);
        p = c + 3;
        a_stb[p] = 1;
        a_tk[p] = tk;
        for (int j = 0; j < n; j++)
          a_tone[p+j] = (tk != 0 && j < n - GC) ? (((j / tk) % 2) == 1) : 0;
        c = p + n;
        if (idx == SD - 1) begin
          idx = 0;
          if (!lp) begin
            a_done[c] = 1;
            last = c;
            fin = 1;
          end
        end else begin
          idx++;
        end
      end
    end
    endc = fin ? ((last < stop_at) ? last : stop_at) : stop_at;
    for (int i = 1; i <= endc; i++) a_busy[i] = 1;
    for (int i = 0; i <= endc + 1; i++) begin
      if (i > endc) begin
        a_rom[i] = 0; a_stb[i] = 0; a_done[i] = 0; a_tone[i] = 0;
      end
      if (a_rom[i])   push_ev(0, a_addr[i], base + i);
      if (a_stb[i])   push_ev(1, a_tk[i], base + i);
      if (a_done[i])  push_ev(2, 0, base + i);
      if (a_tone[i] != pt) push_ev(3, int'(a_tone[i]), base + i);
      if (a_busy[i] != pb) push_ev(4, int'(a_busy[i]), base + i);
      pt = a_tone[i];
      pb = a_busy[i];
    end
    return endc;
  endfunction

  function automatic logic [RW-1:0] mk(int code, int tk);
    return {DB'(code), TB'(tk)};
  endfunction

  task automatic play(int song, bit lp, int scale, int stop_at, bit sas);
    int endc;
    int base;
    @(posedge clk); #1;
    song_sel = SW'(song);
    loop_en = lp;
    tempo_scale = 2'(scale);
    start = 1;
    base = cyc;
    endc = run_model(song, lp, scale, stop_at, base);
    stop = (stop_at == 0);
    @(posedge clk); #1;
    start = 0;
    stop = 0;
    loop_en = 1'($urandom);
    while (cyc <= base + endc + 3) begin
      stop = (cyc == base + stop_at);
      start = (stop && sas) ||
              (cyc <= base + endc && $urandom_range(0, 9) == 0);
      song_sel = SW'($urandom);
      @(posedge clk); #1;
    end
    stop = 0;
    start = 0;
    chk("scoreboard_drained", expq.size(), 0);
    expq.delete();
    chk("idle_busy", int'(busy), 0);
    chk("idle_cur_ticks", int'(cur_ticks), 0);
  endtask

  task automatic outs_zero(string tag);
    chk({tag, "_tone"}, int'(tone), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_cur_ticks"}, int'(cur_ticks), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_rom_en"}, int'(rom_en), 0);
    chk({tag, "_note_strobe"}, int'(note_strobe), 0);
  endtask

  function automatic int rand_ticks();
    case ($urandom_range(0, 5))
      0: return 0;
      4: return 113636;
      5: return $urandom_range(1, (1 << TB) - 1);
      default: return $urandom_range(1, 12);
    endcase
  endfunction

  function automatic int rand_code();
    int pick [3] = '{0, 6, 7};
    if ($urandom_range(0, 19) < 2) return pick[$urandom_range(0, 2)];
    return $urandom_range(1, 5);
  endfunction

  initial begin
    for (int i = 0; i < NS*SD; i++) rom[i] = RW'($urandom);
    repeat (3) @(posedge clk);
    #1;
    outs_zero("reset");
    clr_n = 1;
    mon_en = 1;

    rom[0] = mk(1, 7);
    rom[1] = mk(0, 0);
    play(0, 0, 0, NOSTOP, 0);

    rom[SD+0] = mk(2, 0);
    rom[SD+1] = mk(4, 5);
    rom[SD+2] = mk(0, 99);
    play(1, 1, 0, 500, 0);

    rom[2*SD] = mk(0, 3);
    play(2, 1, 0, NOSTOP, 0);
    rom[2*SD] = mk(7, 3);
    play(2, 0, 0, NOSTOP, 0);

    play(0, 0, 1, NOSTOP, 0);
    play(0, 0, 2, NOSTOP, 0);
    play(0, 0, 3, NOSTOP, 0);

    play(0, 0, 0, 50, 1);
    play(0, 0, 0, 0, 0);
    play(0, 0, 0, NOSTOP, 0);

    for (int i = 0; i < SD; i++)
      rom[3*SD + i] = mk($urandom_range(4, 5), $urandom_range(0, 6));
    play(3, 0, 1, NOSTOP, 0);
    play(3, 1, 1, 1200, 0);

    for (int r = 0; r < 12; r++) begin
      int s;
      int len;
      bit lp;
      int sc;
      int st;
      s = $urandom_range(0, NS - 1);
      len = $urandom_range(1, 6);
      for (int i = 0; i < SD; i++)
        rom[s*SD + i] = (i < len) ? mk(rand_code(), rand_ticks())
                                  : mk(0, $urandom_range(0, 99));
      lp = 1'($urandom);
      sc = $urandom_range(0, 3);
      if (lp)                           st = $urandom_range(5, 1500);
      else if ($urandom_range(0, 2) == 0) st = $urandom_range(0, 800);
      else                              st = NOSTOP;
      play(s, lp, sc, st, 1'($urandom));
    end

    // Asynchronous reset in the middle of a sounding note.
    mon_en = 0;
    rom[0] = mk(1, 7);
    rom[1] = mk(0, 0);
    @(posedge clk); #1;
    song_sel = '0;
    loop_en = 0;
    tempo_scale = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (13) @(posedge clk);
    #1;
    chk("pre_reset_tone", int'(tone), 1);
    chk("pre_reset_busy", int'(busy), 1);
    clr_n = 0;
    #1;
    outs_zero("async_reset");
    repeat (2) @(posedge clk);
    #1;
    clr_n = 1;
    begin
      int n = 0;
      repeat (8) begin
        @(negedge clk);
        if (rom_en !== 1'b0 || busy !== 1'b0) n++;
      end
      chk("post_reset_idle", n, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
